rm_alert_collector: RTL and testbench
=====================================

// Module: rm_alert_collector
// PURPOSE
//  Downstream of the runtime-monitor lane array. Accumulates per-lane rule-violation bits,
//  picks one violating lane per cycle round-robin and queues {lane, rules} records in a FIFO.
//  Records leave on a valid/ready port to the alert/trap logic. Each captured lane gets a
//  one-cycle lane_reset pulse, which is fed back to the monitor's per-lane reset input.
// PARAMETERS
//  NUM_LANES   5  monitor lanes, must match monitor array
//  NUM_RULES   5  rule bits per lane
//  FIFO_DEPTH  4  alert record entries, power of 2, >=2
//  CNT_W       16 width of saturating total-alert counter
// PORTS
//  clk_i          in   1                    clock
//  rst_i          in   1                    async reset, active-high
//  monitor_i      in   NUM_LANES*NUM_RULES  per-lane rule bits, [lane][rule]
//  lane_reset_o   out  NUM_LANES            registered one-cycle reset pulse per captured lane
//  alert_valid_o  out  1                    FIFO head valid
//  alert_ready_i  in   1                    consumer accepts head
//  alert_lane_o   out  $clog2(NUM_LANES)    lane index of head record
//  alert_rules_o  out  NUM_RULES            accumulated rule bits of head record (never 0)
//  backpressure_o out  1                    FIFO full and at least one lane pending
//  alert_total_o  out  CNT_W                records pushed since reset, saturating
// BEHAVIOUR
//  Reset: pend, FIFO, lane_reset_o, alert_total_o and backpressure_o are 0.
//   alert_valid_o=0. RR pointer = NUM_LANES-1, so lane 0 wins first.
//  Accumulate: each cycle pend[l] <= pend[l] | (lane_reset_o[l] ? 0 : monitor_i[l]).
//   While a lane's reset pulse is high, that lane's monitor bits are stale and ignored.
//  Candidate set: lanes with pend[l]!=0.
//   Capture is enabled when FIFO count < FIFO_DEPTH, using the registered count.
//   A pop in the same cycle does NOT free a slot for a push in that cycle.
//  Grant: rotating priority. Search starts at ptr+1 and wraps modulo NUM_LANES.
//   On a grant, ptr <= granted lane. With no grant, ptr holds.
//  On grant g:
//   - push {g, pend[g]}
//   - pend[g] <= 0; new bits arriving for g in that same cycle are dropped (the lane is reset next)
//   - lane_reset_o <= onehot(g) for exactly one cycle
//   - alert_total_o += 1, saturating at all-ones
//  No grant: lane_reset_o <= 0.
//  Full FIFO: no capture and no lane reset. Pend keeps OR-accumulating, so no rule bit is lost.
//   backpressure_o is registered: next value = full & |pend.
//  Latency: monitor bit at cycle t -> pend at t+1 -> push at end of t+1 -> alert_valid_o at t+2.
//   This holds with an empty FIFO and no competing lanes.
//   lane_reset_o[g] is high in cycle t+2.
//  Output handshake: pop on alert_valid_o & alert_ready_i.
//   Head data is stable while valid & !ready.
//   Empty FIFO: alert_valid_o=0 and head fields are don't-care (driven 0).
//  Simultaneous push+pop with 0 < count < DEPTH: count unchanged, order preserved.
//  Pointers wrap at FIFO_DEPTH via natural binary overflow of $clog2(FIFO_DEPTH) bits.
//   Count is $clog2(FIFO_DEPTH)+1 bits.
//  Reset asserted mid-operation: all state clears asynchronously, queued records are discarded,
//   and no lane_reset pulse is issued during or after reset.
// STRUCTURE
//  rm_pkg: typedef rm_alert_t {lane_idx, rule_vec}; localparams LANE_W=$clog2(NUM_LANES) and PTR_W.
//  Sub-module rm_rr_arbiter (NUM_REQ): req vector + ptr -> onehot grant + index, combinational.
//  FIFO, pend array, counter and reset-pulse regs are inline in rm_alert_collector.
// TESTING
//  1 Single event: monitor_i[2]=5'b00100 for 1 cycle at t ->
//     alert_valid_o=1, lane=2, rules=00100 at t+2; lane_reset_o=5'b00100 at t+2 only; total=1.
//  2 Round-robin: lanes 0,1,3 pulse rule 0 simultaneously, ready=1 ->
//     records pushed in order lane 0,1,3 on consecutive cycles; next lone lane-0 event after lane 3.
//  3 Accumulate: lane 4 rule1 at t, rule3 at t+3, FIFO held full ->
//     after one pop, a single record lane=4, rules=01010; backpressure_o=1 while full.
//  4 Reset-window mask: lane 1 captured, monitor_i[1]=1 during its lane_reset_o cycle ->
//     no second record for lane 1.
//  5 Backpressure: ready=0, 6 distinct lane events, DEPTH=4 ->
//     exactly 4 records queued, 4 reset pulses, remaining lanes pending;
//     ready=1 drains all 6 in RR order, head stable while stalled.
//  6 Saturation/reset: CNT_W=4 with 20 alerts -> total=15; assert rst_i mid-stream ->
//     valid=0, total=0, lane_reset_o=0 immediately (async).

Source files
------------

// File: rtl/rm_pkg.sv
// Shared types and widths for the runtime-monitor alert collector.
// The alert record layout is fixed by the default lane/rule/FIFO geometry below.
package rm_pkg;

    localparam int unsigned RM_NUM_LANES  = 5;
    localparam int unsigned RM_NUM_RULES  = 5;
    localparam int unsigned RM_FIFO_DEPTH = 4;
    localparam int unsigned LANE_W        = $clog2(RM_NUM_LANES);
    localparam int unsigned PTR_W         = $clog2(RM_FIFO_DEPTH);

    typedef struct packed {
        logic [LANE_W-1:0]       lane_idx;
        logic [RM_NUM_RULES-1:0] rule_vec;
    } rm_alert_t;

endpackage

// File: rtl/rm_rr_arbiter.sv
// Combinational rotating-priority arbiter: search starts one past ptr_i and wraps.
// Produces a onehot grant, the granted index and a grant-valid flag.
module rm_rr_arbiter #(
    parameter int unsigned NUM_REQ = 5,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] cand_s;

    // First requester found walking forward from ptr_i+1 wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand_s  = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand_s = IDX_W'((32'(ptr_i) + i) % NUM_REQ);
            if (!valid_o && req_i[cand_s]) begin
                valid_o         = 1'b1;
                grant_o[cand_s] = 1'b1;
                idx_o           = cand_s;
            end else begin
                valid_o = valid_o;
            end
        end
    end

endmodule

// File: rtl/rm_alert_collector.sv
// Collects per-lane rule violations, picks one lane per cycle round-robin, queues
// {lane, rules} records in a small FIFO and pulses the captured lane's reset.
module rm_alert_collector
    import rm_pkg::*;
#(
    parameter int unsigned NUM_LANES  = RM_NUM_LANES,
    parameter int unsigned NUM_RULES  = RM_NUM_RULES,
    parameter int unsigned FIFO_DEPTH = RM_FIFO_DEPTH,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_LANES*NUM_RULES-1:0] monitor_i,
    output logic [NUM_LANES-1:0]           lane_reset_o,
    output logic                           alert_valid_o,
    input  logic                           alert_ready_i,
    output logic [LANE_W-1:0]              alert_lane_o,
    output logic [NUM_RULES-1:0]           alert_rules_o,
    output logic                           backpressure_o,
    output logic [CNT_W-1:0]               alert_total_o
);

    localparam int unsigned CNT_FW = PTR_W + 1;

    logic [NUM_RULES-1:0] pend_q [NUM_LANES];
    logic [NUM_RULES-1:0] pend_d [NUM_LANES];
    logic [NUM_LANES-1:0] req_s;
    logic [NUM_LANES-1:0] grant_oh_s;
    logic [LANE_W-1:0]    grant_idx_s;
    logic                 grant_vld_s;
    logic [LANE_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_LANES-1:0] lane_reset_q, lane_reset_d;
    rm_alert_t            fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_FW-1:0]    count_q, count_d;
    logic [CNT_W-1:0]     total_q, total_d;
    logic                 bp_q, bp_d;
    logic                 full_s, push_s, pop_s, any_pend_s;

    // Requests are lanes with pending bits; a full FIFO (registered count) masks them all.
    always_comb begin
        full_s     = (count_q == CNT_FW'(FIFO_DEPTH));
        any_pend_s = 1'b0;
        req_s      = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            req_s[l]   = (|pend_q[l]) & ~full_s;
            any_pend_s = any_pend_s | (|pend_q[l]);
        end
    end

    rm_rr_arbiter #(
        .NUM_REQ (NUM_LANES),
        .IDX_W   (LANE_W)
    ) u_arb (
        .req_i   (req_s),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_oh_s),
        .idx_o   (grant_idx_s),
        .valid_o (grant_vld_s)
    );

    assign push_s        = grant_vld_s;
    assign alert_valid_o = (count_q != '0);
    assign pop_s         = alert_valid_o & alert_ready_i;

    // Next-state: accumulate, clear granted lane, pulse, pointers, counters.
    always_comb begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            pend_d[l] = pend_q[l];
            if (grant_vld_s && grant_oh_s[l]) begin
                pend_d[l] = '0;
            end else if (lane_reset_q[l]) begin
                pend_d[l] = pend_q[l];
            end else begin
                pend_d[l] = pend_q[l] | monitor_i[l*NUM_RULES +: NUM_RULES];
            end
        end
        lane_reset_d = grant_vld_s ? grant_oh_s : '0;
        rr_ptr_d     = grant_vld_s ? grant_idx_s : rr_ptr_q;
        count_d      = count_q + CNT_FW'(push_s) - CNT_FW'(pop_s);
        if (push_s && (total_q != '1)) begin
            total_d = total_q + CNT_W'(1);
        end else begin
            total_d = total_q;
        end
        bp_d = full_s & any_pend_s;
    end

    // Control and bookkeeping registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                pend_q[l] <= '0;
            end
            rr_ptr_q     <= LANE_W'(NUM_LANES - 1);
            lane_reset_q <= '0;
            count_q      <= '0;
            total_q      <= '0;
            bp_q         <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            for (int unsigned l = 0; l < NUM_LANES; l++) begin
                pend_q[l] <= pend_d[l];
            end
            rr_ptr_q     <= rr_ptr_d;
            lane_reset_q <= lane_reset_d;
            count_q      <= count_d;
            total_q      <= total_d;
            bp_q         <= bp_d;
            wr_ptr_q     <= push_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
            rd_ptr_q     <= pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        end
    end

    // Record storage; the pushed rule vector is the pre-clear pending value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned e = 0; e < FIFO_DEPTH; e++) begin
                fifo_q[e] <= '0;
            end
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= '{lane_idx: grant_idx_s, rule_vec: pend_q[grant_idx_s]};
        end else begin
            fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
        end
    end

    // Head fields are forced to zero when the FIFO is empty.
    always_comb begin
        if (alert_valid_o) begin
            alert_lane_o  = fifo_q[rd_ptr_q].lane_idx;
            alert_rules_o = fifo_q[rd_ptr_q].rule_vec;
        end else begin
            alert_lane_o  = '0;
            alert_rules_o = '0;
        end
    end

    assign lane_reset_o   = lane_reset_q;
    assign backpressure_o = bp_q;
    assign alert_total_o  = total_q;

endmodule

// File: tb/tb_rm_alert_collector.sv
// Directed self-checking bench for rm_alert_collector (4-bit total counter instance).
module tb_rm_alert_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] monitor = '0;
    logic [4:0]  lane_reset;
    logic        valid;
    logic        ready = 1'b0;
    logic [2:0]  lane;
    logic [4:0]  rules;
    logic        bp;
    logic [3:0]  total;

    int n_chk  = 0;
    int n_pass = 0;

    rm_alert_collector #(
        .NUM_LANES  (5),
        .NUM_RULES  (5),
        .FIFO_DEPTH (4),
        .CNT_W      (4)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .monitor_i      (monitor),
        .lane_reset_o   (lane_reset),
        .alert_valid_o  (valid),
        .alert_ready_i  (ready),
        .alert_lane_o   (lane),
        .alert_rules_o  (rules),
        .backpressure_o (bp),
        .alert_total_o  (total)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mon(input int l, input logic [4:0] r);
        monitor[l*5 +: 5] = r;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        monitor = '0;
        ready   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (valid !== 1'b0) $display("FAIL rst_valid got %0h exp 0", valid); else n_pass++;
        n_chk++; if (lane_reset !== 5'b00000) $display("FAIL rst_lane_reset got %0h exp 0", lane_reset); else n_pass++;
        n_chk++; if (total !== 4'd0) $display("FAIL rst_total got %0d exp 0", total); else n_pass++;
        n_chk++; if (bp !== 1'b0) $display("FAIL rst_bp got %0h exp 0", bp); else n_pass++;
        n_chk++; if ({lane, rules} !== 8'h00) $display("FAIL rst_head got %0h exp 0", {lane, rules}); else n_pass++;
    endtask

    task automatic test_single_event();
        do_reset();
        set_mon(2, 5'b00100);
        step();
        monitor = '0;
        n_chk++; if (valid !== 1'b0) $display("FAIL t1_valid_early got %0h exp 0", valid); else n_pass++;
        n_chk++; if (lane_reset !== 5'b00000) $display("FAIL t1_lr_early got %0h exp 0", lane_reset); else n_pass++;
        step();
        n_chk++; if (valid !== 1'b1) $display("FAIL t1_valid got %0h exp 1", valid); else n_pass++;
        n_chk++; if (lane !== 3'd2) $display("FAIL t1_lane got %0d exp 2", lane); else n_pass++;
        n_chk++; if (rules !== 5'b00100) $display("FAIL t1_rules got %b exp 00100", rules); else n_pass++;
        n_chk++; if (lane_reset !== 5'b00100) $display("FAIL t1_lr got %b exp 00100", lane_reset); else n_pass++;
        n_chk++; if (total !== 4'd1) $display("FAIL t1_total got %0d exp 1", total); else n_pass++;
        step();
        n_chk++; if (lane_reset !== 5'b00000) $display("FAIL t1_lr_once got %b exp 00000", lane_reset); else n_pass++;
        n_chk++; if (valid !== 1'b1) $display("FAIL t1_hold got %0h exp 1", valid); else n_pass++;
        ready = 1'b1;
        step();
        ready = 1'b0;
        n_chk++; if (valid !== 1'b0) $display("FAIL t1_popped got %0h exp 0", valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        set_mon(0, 5'b00001);
        set_mon(1, 5'b00001);
        set_mon(3, 5'b00001);
        step();
        monitor = '0;
        ready   = 1'b1;
        step();
        n_chk++; if ({lane, rules} !== {3'd0, 5'b00001}) $display("FAIL t2_rec0 got %0d/%b exp 0/00001", lane, rules); else n_pass++;
        n_chk++; if (lane_reset !== 5'b00001) $display("FAIL t2_lr0 got %b exp 00001", lane_reset); else n_pass++;
        step();
        n_chk++; if ({lane, rules} !== {3'd1, 5'b00001}) $display("FAIL t2_rec1 got %0d/%b exp 1/00001", lane, rules); else n_pass++;
        n_chk++; if (lane_reset !== 5'b00010) $display("FAIL t2_lr1 got %b exp 00010", lane_reset); else n_pass++;
        step();
        n_chk++; if ({valid, lane, rules} !== {1'b1, 3'd3, 5'b00001}) $display("FAIL t2_rec3 got %0h/%0d/%b exp 1/3/00001", valid, lane, rules); else n_pass++;
        n_chk++; if (lane_reset !== 5'b01000) $display("FAIL t2_lr3 got %b exp 01000", lane_reset); else n_pass++;
        n_chk++; if (total !== 4'd3) $display("FAIL t2_total3 got %0d exp 3", total); else n_pass++;
        set_mon(0, 5'b00001);
        step();
        monitor = '0;
        n_chk++; if (valid !== 1'b0) $display("FAIL t2_gap got %0h exp 0", valid); else n_pass++;
        step();
        n_chk++; if ({valid, lane, rules} !== {1'b1, 3'd0, 5'b00001}) $display("FAIL t2_lone0 got %0h/%0d/%b exp 1/0/00001", valid, lane, rules); else n_pass++;
        n_chk++; if (total !== 4'd4) $display("FAIL t2_total4 got %0d exp 4", total); else n_pass++;
        step();
        ready = 1'b0;
        n_chk++; if (valid !== 1'b0) $display("FAIL t2_drained got %0h exp 0", valid); else n_pass++;
    endtask

    task automatic test_accumulate();
        logic [2:0] exp_lane [4];
        logic [4:0] exp_rules [4];
        exp_lane  = '{3'd1, 3'd2, 3'd3, 3'd4};
        exp_rules = '{5'b00001, 5'b00001, 5'b00001, 5'b01010};
        do_reset();
        for (int l = 0; l < 4; l++) set_mon(l, 5'b00001);
        step();
        monitor = '0;
        repeat (4) step();
        set_mon(4, 5'b00010);
        step();
        monitor = '0;
        step();
        step();
        set_mon(4, 5'b01000);
        step();
        monitor = '0;
        n_chk++; if (bp !== 1'b1) $display("FAIL t3_bp got %0h exp 1", bp); else n_pass++;
        n_chk++; if (total !== 4'd4) $display("FAIL t3_total_full got %0d exp 4", total); else n_pass++;
        n_chk++; if (lane_reset !== 5'b00000) $display("FAIL t3_lr_full got %b exp 00000", lane_reset); else n_pass++;
        n_chk++; if ({lane, rules} !== {3'd0, 5'b00001}) $display("FAIL t3_head0 got %0d/%b exp 0/00001", lane, rules); else n_pass++;
        ready = 1'b1;
        step();
        ready = 1'b0;
        step();
        n_chk++; if (lane_reset !== 5'b10000) $display("FAIL t3_lr4 got %b exp 10000", lane_reset); else n_pass++;
        ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({valid, lane, rules} !== {1'b1, exp_lane[i], exp_rules[i]})
                $display("FAIL t3_rec%0d got %0h/%0d/%b exp 1/%0d/%b", i, valid, lane, rules, exp_lane[i], exp_rules[i]);
            else n_pass++;
            step();
        end
        ready = 1'b0;
        n_chk++; if (valid !== 1'b0) $display("FAIL t3_single got %0h exp 0", valid); else n_pass++;
        n_chk++; if (bp !== 1'b0) $display("FAIL t3_bp_clear got %0h exp 0", bp); else n_pass++;
        n_chk++; if (total !== 4'd5) $display("FAIL t3_total got %0d exp 5", total); else n_pass++;
    endtask

    task automatic test_reset_mask();
        do_reset();
        set_mon(1, 5'b00001);
        step();
        monitor = '0;
        step();
        n_chk++; if (lane_reset !== 5'b00010) $display("FAIL t4_lr got %b exp 00010", lane_reset); else n_pass++;
        set_mon(1, 5'b00001);
        ready = 1'b1;
        step();
        monitor = '0;
        n_chk++; if (valid !== 1'b0) $display("FAIL t4_popped got %0h exp 0", valid); else n_pass++;
        step();
        step();
        n_chk++; if (valid !== 1'b0) $display("FAIL t4_no_second got %0h exp 0", valid); else n_pass++;
        n_chk++; if (total !== 4'd1) $display("FAIL t4_total got %0d exp 1", total); else n_pass++;
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [2:0] exp_lane [6];
        logic [4:0] exp_rules [6];
        int pulses;
        exp_lane  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        exp_rules = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b10000};
        pulses = 0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) for (int l = 0; l < 5; l++) set_mon(l, 5'(1 << l));
            if (i == 1) monitor = '0;
            if (i == 3) set_mon(0, 5'b10000);
            if (i == 4) monitor = '0;
            step();
            pulses += $countones(lane_reset);
        end
        n_chk++; if (pulses !== 4) $display("FAIL t5_pulses got %0d exp 4", pulses); else n_pass++;
        n_chk++; if (total !== 4'd4) $display("FAIL t5_total4 got %0d exp 4", total); else n_pass++;
        n_chk++; if (bp !== 1'b1) $display("FAIL t5_bp got %0h exp 1", bp); else n_pass++;
        n_chk++; if ({valid, lane, rules} !== {1'b1, 3'd0, 5'b00001}) $display("FAIL t5_head got %0h/%0d/%b exp 1/0/00001", valid, lane, rules); else n_pass++;
        step();
        n_chk++; if ({valid, lane, rules} !== {1'b1, 3'd0, 5'b00001}) $display("FAIL t5_stable got %0h/%0d/%b exp 1/0/00001", valid, lane, rules); else n_pass++;
        ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n_chk++;
            if ({valid, lane, rules} !== {1'b1, exp_lane[i], exp_rules[i]})
                $display("FAIL t5_rec%0d got %0h/%0d/%b exp 1/%0d/%b", i, valid, lane, rules, exp_lane[i], exp_rules[i]);
            else n_pass++;
            step();
        end
        ready = 1'b0;
        n_chk++; if (valid !== 1'b0) $display("FAIL t5_empty got %0h exp 0", valid); else n_pass++;
        n_chk++; if (total !== 4'd6) $display("FAIL t5_total6 got %0d exp 6", total); else n_pass++;
    endtask

    task automatic test_saturation_reset();
        do_reset();
        ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            monitor = '0;
            set_mon(k % 5, 5'b00001);
            step();
        end
        monitor = '0;
        repeat (4) step();
        n_chk++; if (total !== 4'd15) $display("FAIL t6_sat got %0d exp 15", total); else n_pass++;
        n_chk++; if (valid !== 1'b0) $display("FAIL t6_drained got %0h exp 0", valid); else n_pass++;
        ready = 1'b0;
        set_mon(0, 5'b00001);
        set_mon(1, 5'b00001);
        step();
        monitor = '0;
        step();
        n_chk++; if (lane_reset !== 5'b00001) $display("FAIL t6_pre_lr got %b exp 00001", lane_reset); else n_pass++;
        rst = 1'b1;
        #1;
        n_chk++; if (valid !== 1'b0) $display("FAIL t6_async_valid got %0h exp 0", valid); else n_pass++;
        n_chk++; if (total !== 4'd0) $display("FAIL t6_async_total got %0d exp 0", total); else n_pass++;
        n_chk++; if (lane_reset !== 5'b00000) $display("FAIL t6_async_lr got %b exp 00000", lane_reset); else n_pass++;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_chk++;
            if ({valid, lane_reset} !== 6'b0) $display("FAIL t6_post%0d got %0h/%b exp 0/00000", i, valid, lane_reset);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_round_robin();
        test_accumulate();
        test_reset_mask();
        test_backpressure();
        test_saturation_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
